wts_channel_mixer: RTL

WTS_CHANNEL_MIXER -- requirements
Module: wts_channel_mixer

---
 rtl/wts_mixer_pkg.sv | 28 ++
 rtl/wts_mixer_saturate.sv | 28 ++
 rtl/wts_channel_mixer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/wts_mixer_pkg.sv
// Shared types and constants for the wave-table channel mixer.
// Holds the FSM encoding, datapath widths and output saturation limits.
package wts_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  localparam int ACC_W    = 21;
  localparam int PROD_W   = 18;
  localparam int OUT_W    = 16;
  localparam int ENV_W    = 9;
  localparam int WADDR_W  = 7;
  localparam int SAMP_W   = 8;
  localparam int CH_W     = 3;
  localparam int SRAM_A_W = CH_W + WADDR_W;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  function automatic logic signed [ACC_W-1:0] prod_to_acc(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/wts_mixer_saturate.sv
// Combinational output scaling: (acc <<< gain) >>> 3, clamped to a signed 16-bit sample.
module wts_mixer_saturate
  import wts_mixer_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [1:0]       gain,
  output logic signed [OUT_W-1:0] sat
);

  localparam int W = ACC_W + 3;

  logic signed [W-1:0] ext;
  logic signed [W-1:0] scaled;

  always_comb begin
    // Three guard bits keep the maximum left shift of the accumulator lossless.
    ext    = {{3{acc[ACC_W-1]}}, acc};
    scaled = (ext <<< gain) >>> 3;
    if (scaled > SAT_MAX) begin
      sat = OUT_W'(SAT_MAX);
    end else if (scaled < SAT_MIN) begin
      sat = OUT_W'(SAT_MIN);
    end else begin
      sat = scaled[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/wts_channel_mixer.sv
// Wave-table channel mixer: fetches one sample per channel, scales by envelope and sums.
// Optional per-channel mute port reg_ch_mute is enabled by defining WTS_MIXER_MUTE_EN.
module wts_channel_mixer
  import wts_mixer_pkg::*;
#(
  parameter int CH_NUM = 8
)
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        active,
  input  logic [ENV_W*CH_NUM-1:0]     ch_envelope,
  input  logic [WADDR_W*CH_NUM-1:0]   ch_sram_a,
  output logic [SRAM_A_W-1:0]         sram_a,
  input  logic [SAMP_W-1:0]           sram_q,
  input  logic [1:0]                  reg_master_gain,
`ifdef WTS_MIXER_MUTE_EN
  input  logic [CH_NUM-1:0]           reg_ch_mute,
`endif
  output logic [OUT_W-1:0]            sample,
  output logic                        sample_valid,
  output logic                        overrun
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CH_NUM - 1);

  state_e                     state_q, state_d;
  logic [CH_W-1:0]            cnt_q, cnt_d;
  logic                       drain_q, drain_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [SRAM_A_W-1:0]        sram_a_q, sram_a_d;
  logic [ENV_W-1:0]           env1_q, env1_d, env2_q, env2_d;
  logic                       mute1_q, mute1_d, mute2_q, mute2_d;
  logic                       issue_vld_q, issue_vld_d;
  logic                       rd_vld_q, rd_vld_d;
  logic                       prod_vld_q, prod_vld_d;
  logic signed [PROD_W-1:0]   prod_q, prod_d;
  logic signed [OUT_W-1:0]    sample_q, sample_d;
  logic                       sample_valid_q, sample_valid_d;
  logic                       overrun_q, overrun_d;

  logic                       issue;
  logic [CH_W-1:0]            issue_ch;
  logic signed [PROD_W-1:0]   q_ext, env_ext, mult;
  logic signed [OUT_W-1:0]    sat_out;

  wts_mixer_saturate u_sat (
    .acc  (acc_q),
    .gain (reg_master_gain),
    .sat  (sat_out)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    drain_d        = drain_q;
    acc_d          = acc_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    overrun_d      = 1'b0;
    issue          = 1'b0;
    issue_ch       = '0;

    if (prod_vld_q) begin
      acc_d = acc_q + prod_to_acc(prod_q);
    end

    case (state_q)
      IDLE: begin
        if (active) begin
          acc_d    = '0;
          cnt_d    = '0;
          issue    = 1'b1;
          issue_ch = '0;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        overrun_d = active;
        if (cnt_q == LAST_CH) begin
          drain_d = 1'b0;
          state_d = DRAIN;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          issue    = 1'b1;
          issue_ch = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        overrun_d = active;
        // Two cycles let the last read and multiply land in the accumulator.
        if (drain_q) begin
          state_d = OUTPUT;
        end else begin
          drain_d = 1'b1;
        end
      end
      OUTPUT: begin
        overrun_d      = active;
        sample_d       = sat_out;
        sample_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sram_a_d    = sram_a_q;
    env1_d      = env1_q;
    mute1_d     = mute1_q;
    issue_vld_d = issue;
    if (issue) begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (issue_ch == CH_W'(c)) begin
          sram_a_d = {CH_W'(c), ch_sram_a[WADDR_W*c +: WADDR_W]};
          env1_d   = ch_envelope[ENV_W*c +: ENV_W];
`ifdef WTS_MIXER_MUTE_EN
          mute1_d  = reg_ch_mute[c];
`else
          mute1_d  = 1'b0;
`endif
        end
      end
    end
  end

  // Envelope and mute ride one stage behind the address to meet the RAM read data.
  always_comb begin
    rd_vld_d   = issue_vld_q;
    env2_d     = env1_q;
    mute2_d    = mute1_q;
    prod_vld_d = rd_vld_q;
    q_ext      = {{(PROD_W-SAMP_W){sram_q[SAMP_W-1]}}, sram_q};
    env_ext    = {{(PROD_W-ENV_W){1'b0}}, env2_q};
    mult       = q_ext * env_ext;
    prod_d     = mute2_q ? '0 : mult;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      drain_q        <= 1'b0;
      acc_q          <= '0;
      sram_a_q       <= '0;
      env1_q         <= '0;
      env2_q         <= '0;
      mute1_q        <= 1'b0;
      mute2_q        <= 1'b0;
      issue_vld_q    <= 1'b0;
      rd_vld_q       <= 1'b0;
      prod_vld_q     <= 1'b0;
      prod_q         <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      drain_q        <= drain_d;
      acc_q          <= acc_d;
      sram_a_q       <= sram_a_d;
      env1_q         <= env1_d;
      env2_q         <= env2_d;
      mute1_q        <= mute1_d;
      mute2_q        <= mute2_d;
      issue_vld_q    <= issue_vld_d;
      rd_vld_q       <= rd_vld_d;
      prod_vld_q     <= prod_vld_d;
      prod_q         <= prod_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign sram_a       = sram_a_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule
